iiitb_uart_tx: RTL and testbench

UART serial transmitter that sits directly downstream of the baud rate generator `iiitb_brg` and consumes its `clkout` as a once-per-bit enable. It accepts parallel bytes over a valid/ready handshake and shifts out asynchronous serial frames: start bit, data bits LSB first, optional parity, then stop bit(s). Everything runs in the single system clock domain; `clkout` is treated as data and edge-detected, never used as a clock.

---
 rtl/iiitb_uart_tx.sv | 136 +++++++++++++
 tb/tb_iiitb_uart_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// One bit per rising edge of baud_clk, which is edge-detected as data in the clk domain.
module iiitb_uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam logic [3:0] LP_DATA_BITS = 4'(DATA_BITS);
    localparam logic [1:0] LP_STOP_BITS = 2'(STOP_BITS);
    localparam logic       LP_PAR_EN    = (PARITY_EN != 0);
    localparam logic       LP_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_baud_q;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_parity;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic [1:0]           r_stop_cnt;
    logic                 w_tick;

    // baud_q resets high so a baud_clk already high at reset release is not a tick
    assign w_tick = baud_clk & ~r_baud_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_q   <= 1'b1;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_parity   <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
        end else begin
            r_baud_q <= baud_clk;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid && r_ready) begin
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ LP_PAR_ODD;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_WAIT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt < LP_DATA_BITS) begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (LP_PAR_EN) begin
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 2'd1;
                            r_state    <= S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 2'd1;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_stop_cnt < LP_STOP_BITS) begin
                            r_stop_cnt <= r_stop_cnt + 2'd1;
                        end else begin
                            r_stop_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;

endmodule

// File: tb/tb_iiitb_uart_tx.sv
// Scoreboard bench for iiitb_uart_tx: expected frames are queued on accept and
// checked bit-by-bit (level and exact 16-clk duration) as the line toggles.
module tb_iiitb_uart_tx;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_auto = 1'b1;
    logic       baud_gen  = 1'b0;
    logic       baud_man  = 1'b0;
    logic       baud_clk;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_w    [4];
    logic       ready_w [4];
    logic       busy_w  [4];

    int vectors     = 0;
    int miscompares = 0;
    int sel         = 0;
    int baud_cnt    = 0;

    logic exp_q  [$];
    int   flen_q [$];

    always #5 clk = ~clk;

    // 16-clk baud period, 8 high / 8 low, changing away from the active edge
    always @(negedge clk) begin
        baud_cnt = (baud_cnt + 1) % 16;
        baud_gen = (baud_cnt < 8);
    end

    assign baud_clk = baud_auto ? baud_gen : baud_man;

    iiitb_uart_tx u_8n1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0])
    );
    iiitb_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1])
    );
    iiitb_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2])
    );
    iiitb_uart_tx #(.STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3])
    );

    // Reference frame for DUT d: 0, data LSB first, optional parity, stop bits
    task automatic push_frame(input int d, input logic [7:0] data);
        int   par_en;
        int   stops;
        logic odd;
        par_en = ((d == 1) || (d == 2)) ? 1 : 0;
        odd    = (d == 2);
        stops  = (d == 3) ? 2 : 1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
        if (par_en != 0) exp_q.push_back((^data) ^ odd);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
        flen_q.push_back(1 + 8 + par_en + stops);
    endtask

    always @(posedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1 && ready_w[sel] === 1'b1)
            push_frame(sel, tx_data);
    end

    task automatic drain(input int d, input int nframes, input bit gapcheck);
        int   hi;
        bit   seen;
        int   len;
        logic e;
        logic got;
        bit   ok;
        for (int f = 0; f < nframes; f++) begin
            hi   = 0;
            seen = 0;
            while (hi < 600 && !seen) begin
                @(negedge clk);
                if (tx_w[d] === 1'b0) seen = 1;
                else hi++;
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL start_bit dut%0d frame%0d: line high for %0d cycles, required a start bit", d, f, hi);
                return;
            end
            if (f > 0 && gapcheck) begin
                vectors++;
                if (hi !== 16) begin
                    miscompares++;
                    $display("FAIL idle_gap dut%0d: idle high %0d cycles, required 16", d, hi);
                end
            end
            vectors++;
            if (flen_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame dut%0d: frame started with no queued byte, required none", d);
                return;
            end
            len = flen_q.pop_front();
            for (int b = 0; b < len; b++) begin
                e   = exp_q.pop_front();
                ok  = 1;
                got = e;
                for (int s = 0; s < 16; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (tx_w[d] !== e && ok) begin
                        ok  = 0;
                        got = tx_w[d];
                    end
                end
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL frame_bit dut%0d frame%0d bit%0d: got %b within the 16-clk period, required %b", d, f, b, got, e);
                end
            end
        end
    endtask

    task automatic accept_byte(input int d, input logic [7:0] data);
        int n;
        n        = 0;
        tx_data  = data;
        tx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (busy_w[d] !== 1'b1 && n < 50);
        tx_valid = 1'b0;
        vectors++;
        if (busy_w[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL accept dut%0d: tx_busy=%b after %0d cycles, required 1", d, busy_w[d], n);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        flen_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        reset    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                vectors++;
                if ({tx_w[d], ready_w[d], busy_w[d]} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL reset_hold dut%0d cyc%0d: tx/ready/busy=%b, required 100", d, c, {tx_w[d], ready_w[d], busy_w[d]});
                end
            end
        end
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if ({tx_w[d], ready_w[d], busy_w[d]} !== 3'b110) begin
                miscompares++;
                $display("FAIL reset_release dut%0d: tx/ready/busy=%b, required 110", d, {tx_w[d], ready_w[d], busy_w[d]});
            end
        end
        vectors++;
        if (flen_q.size() != 0) begin
            miscompares++;
            $display("FAIL accept_in_reset: %0d frames accepted, required 0", flen_q.size());
        end
    endtask

    task automatic test_8n1();
        sel = 0;
        apply_reset();
        accept_byte(0, 8'hA5);
        drain(0, 1, 1'b0);
        @(negedge clk);
        vectors++;
        if ({tx_w[0], ready_w[0], busy_w[0]} !== 3'b100) begin
            miscompares++;
            $display("FAIL busy_fall: tx/ready/busy=%b after final stop tick, required 100", {tx_w[0], ready_w[0], busy_w[0]});
        end
        @(negedge clk);
        vectors++;
        if (ready_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_return: tx_ready=%b, required 1", ready_w[0]);
        end
    endtask

    task automatic test_parity();
        for (int d = 1; d <= 2; d++) begin
            sel = d;
            apply_reset();
            accept_byte(d, 8'h07);
            drain(d, 1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        sel = 3;
        apply_reset();
        fork
            drain(3, 2, 1'b1);
            begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                n        = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (busy_w[3] !== 1'b1 && n < 50);
                tx_data = 8'h0F;
                n       = 0;
                while (ready_w[3] !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                vectors++;
                if (ready_w[3] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_rise: tx_ready=%b after %0d cycles, required 1", ready_w[3], n);
                end
                @(negedge clk);
                vectors++;
                if ({ready_w[3], busy_w[3]} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL second_accept: ready/busy=%b one cycle after ready rose, required 01", {ready_w[3], busy_w[3]});
                end
                tx_valid = 1'b0;
            end
        join
    endtask

    task automatic test_reset_midframe();
        int n;
        bit ok;
        sel = 0;
        apply_reset();
        accept_byte(0, 8'hFF);
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start: tx=%b, required start bit 0", tx_w[0]);
        end
        repeat (72) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx_w[0], ready_w[0], busy_w[0]} !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_reset: tx/ready/busy=%b, required 100", {tx_w[0], ready_w[0], busy_w[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        flen_q.delete();
        ok = 1;
        repeat (200) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL abort_quiet: line or busy moved after abort, required tx=1 busy=0");
        end
        accept_byte(0, 8'h00);
        drain(0, 1, 1'b0);
    endtask

    task automatic test_baud_held();
        bit ok;
        sel = 0;
        @(negedge clk);
        baud_man  = 1'b1;
        baud_auto = 1'b0;
        apply_reset();
        accept_byte(0, 8'hC3);
        fork
            drain(0, 1, 1'b0);
            begin
                ok = 1;
                repeat (40) begin
                    @(negedge clk);
                    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b1) ok = 0;
                end
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL held_no_tick: tx/busy moved while baud_clk held high, required tx=1 busy=1");
                end
                baud_man = 1'b0;
                repeat (8) @(negedge clk);
                baud_man = 1'b1;
                @(negedge clk);
                vectors++;
                if (tx_w[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL held_first_rise: tx=%b one clk after first rise, required 0", tx_w[0]);
                end
                for (int k = 0; k < 10; k++) begin
                    repeat (7) @(negedge clk);
                    baud_man = 1'b0;
                    repeat (8) @(negedge clk);
                    baud_man = 1'b1;
                    @(negedge clk);
                end
            end
        join
        baud_auto = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_baud_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
